// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared opcodes, field positions, widths and FSM encodings for the fetch unit
package instr_fetch_unit_pkg;

    localparam int BITS_DATA_DEFAULT = 32;
    localparam int BITS_ADDR_DEFAULT = 16;

    // Opcode field sits in the top five bits of a 32-bit instruction word.
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 27;
    localparam int OPC_WIDTH = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_WIDTH-1:0] OPC_NOP = 5'b00000;
    localparam logic [OPC_WIDTH-1:0] OPC_NOT = 5'b10000;
    localparam logic [OPC_WIDTH-1:0] OPC_AND = 5'b10001;
    localparam logic [OPC_WIDTH-1:0] OPC_OR  = 5'b10010;
    localparam logic [OPC_WIDTH-1:0] OPC_NEG = 5'b10100;
    localparam logic [OPC_WIDTH-1:0] OPC_ADD = 5'b10101;
    localparam logic [OPC_WIDTH-1:0] OPC_SUB = 5'b10110;
    localparam logic [OPC_WIDTH-1:0] OPC_HLT = 5'b11111;

    localparam logic [1:0] ENC_FETCH = 2'd0;
    localparam logic [1:0] ENC_ISSUE = 2'd1;
    localparam logic [1:0] ENC_HALT  = 2'd2;

    typedef enum logic [1:0] {
        ST_FETCH = ENC_FETCH,
        ST_ISSUE = ENC_ISSUE,
        ST_HALT  = ENC_HALT
    } fetch_state_t;

    // Extract the opcode field from a 32-bit instruction word.
    function automatic logic [OPC_WIDTH-1:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC-driven instruction fetcher with valid/ready issue, redirect and halt
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    BITS_DATA = BITS_DATA_DEFAULT,
    parameter int                    BITS_ADDR = BITS_ADDR_DEFAULT,
    parameter logic [BITS_ADDR-1:0]  RESET_PC  = '0,
    parameter logic [OPC_WIDTH-1:0]  OPC_HLT_P = OPC_HLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [BITS_ADDR-1:0] mem_address,
    output logic                 mem_write,
    input  logic [BITS_DATA-1:0] mem_data,
    output logic [BITS_DATA-1:0] instr_out,
    output logic [BITS_ADDR-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 redirect_valid,
    input  logic [BITS_ADDR-1:0] redirect_addr,
    input  logic                 resume,
    output logic                 halted,
    output logic [31:0]          fetch_count
);

    fetch_state_t         state_q;
    fetch_state_t         state_d;
    logic [BITS_ADDR-1:0] pc_q;
    logic [BITS_DATA-1:0] instr_q;
    logic [BITS_ADDR-1:0] instr_pc_q;
    logic                 valid_q;
    logic                 halted_q;
    logic [31:0]          count_q;

    logic                 accept;
    logic                 is_hlt;

    // A redirect cancels any same-cycle handshake, so it is excluded from accept.
    assign accept = (state_q == ST_ISSUE) && valid_q && instr_ready && !redirect_valid;
    assign is_hlt = (opcode_of(instr_q[31:0]) == OPC_HLT_P);

    assign mem_address = pc_q;
    assign mem_write   = 1'b0;
    assign instr_out   = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect overrides every state and returns to fetch.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: state_d = ST_ISSUE;
                ST_ISSUE: begin
                    if (accept) begin
                        state_d = is_hlt ? ST_HALT : ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // PC, captured instruction, handshake flags and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_addr;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // Memory read is combinational on pc, so capture the word this cycle.
                    instr_q    <= mem_data;
                    instr_pc_q <= pc_q;
                    pc_q       <= pc_q + 1'b1;
                    valid_q    <= 1'b1;
                end
                ST_ISSUE: begin
                    if (accept) begin
                        count_q <= count_q + 32'd1;
                        valid_q <= 1'b0;
                        if (is_hlt) begin
                            halted_q <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    valid_q <= 1'b0;
                    if (resume) begin
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_data;
    logic [31:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        resume;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:65535];
    assign mem_data = mem[mem_address];

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;
    int   exp_count = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_data       (mem_data),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .resume         (resume),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem[pc];
        sb.push_back(e);
    endtask

    // Wait (bounded) for a valid instruction, then compare it with the scoreboard head.
    task automatic wait_check(input string tag);
        exp_t e;
        int   n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"}, 64'(instr_pc), 64'(e.pc));
            chk({tag, "_instr"}, 64'(instr_out), 64'(e.instr));
        end
    endtask

    task automatic accept_one(input string tag);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        exp_count++;
        chk({tag, "_count"}, 64'(fetch_count), 64'(exp_count));
        chk({tag, "_valid_drop"}, 64'(instr_valid), 64'd0);
    endtask

    task automatic deliver(input string tag);
        wait_check(tag);
        accept_one(tag);
    endtask

    logic [31:0] prog [0:8];
    logic [31:0] held_instr;

    initial begin
        prog[0] = 32'h00000000; prog[1] = 32'h82000000; prog[2] = 32'h8A000000;
        prog[3] = 32'h92000000; prog[4] = 32'hA2000000; prog[5] = 32'hAA000000;
        prog[6] = 32'hB2000000; prog[7] = 32'hB2000000; prog[8] = 32'hF8000000;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        for (int i = 0; i < 9; i++) mem[i] = prog[i];
        mem[9]  = 32'h12345678;
        mem[10] = 32'h82000000;

        rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_addr = 16'h0; resume = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(fetch_count), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_instr", 64'(instr_out), 64'd0);
        chk("rst_ipc", 64'(instr_pc), 64'd0);
        chk("mem_write", 64'(mem_write), 64'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) push_exp(16'(i));
        for (int i = 0; i < 9; i++) begin
            wait_check($sformatf("seq%0d", i));
            if (i == 3) begin
                held_instr = instr_out;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_valid", 64'(instr_valid), 64'd1);
                    chk("stall_pc", 64'(instr_pc), 64'd3);
                    chk("stall_instr", 64'(instr_out), 64'(held_instr));
                end
            end
            accept_one($sformatf("seq%0d", i));
        end

        chk("hlt_halted", 64'(halted), 64'd1);
        chk("hlt_addr", 64'(mem_address), 64'd9);
        repeat (3) @(negedge clk);
        chk("hlt_hold_halted", 64'(halted), 64'd1);
        chk("hlt_hold_valid", 64'(instr_valid), 64'd0);
        chk("hlt_hold_addr", 64'(mem_address), 64'd9);
        chk("hlt_hold_count", 64'(fetch_count), 64'd9);

        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("resume_halted", 64'(halted), 64'd0);
        push_exp(16'd9);
        deliver("resume");

        redirect_valid = 1'b1; redirect_addr = 16'd4;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir4_valid", 64'(instr_valid), 64'd0);
        chk("redir4_addr", 64'(mem_address), 64'd4);
        push_exp(16'd4);
        wait_check("redir4");
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'd2;
        @(negedge clk);
        instr_ready = 1'b0; redirect_valid = 1'b0;
        chk("cancel_count", 64'(fetch_count), 64'(exp_count));
        chk("cancel_valid", 64'(instr_valid), 64'd0);
        chk("cancel_addr", 64'(mem_address), 64'd2);
        push_exp(16'd2);
        deliver("redir2");

        redirect_valid = 1'b1; redirect_addr = 16'hFFFF;
        @(negedge clk);
        redirect_valid = 1'b0;
        push_exp(16'hFFFF);
        deliver("wrap");
        chk("wrap_addr", 64'(mem_address), 64'd0);
        push_exp(16'd0);
        deliver("wrap_next");

        push_exp(16'd1);
        wait_check("pre_rst");
        rst_n = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; instr_ready = 1'b0;
        exp_count = 0;
        chk("midrst_valid", 64'(instr_valid), 64'd0);
        chk("midrst_count", 64'(fetch_count), 64'd0);
        chk("midrst_addr", 64'(mem_address), 64'd0);
        push_exp(16'd0);
        deliver("restart");
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
